cw_fetch: RTL and testbench

//  Control-word fetch unit; consumer side of the pc block's address/hold interface.

---
 rtl/nisc_pkg.sv | 29 ++
 rtl/cw_fifo.sv | 77 +++++++
 rtl/cw_fetch.sv | 120 ++++++++++++
 tb/tb_cw_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nisc_pkg
//  Purpose  : Shared types and default sizes for the NISC fetch path (pc,
//             cw_fetch, datapath).
//  Contents : fetch_state_t  - fetch FSM state encoding
//             c_PSIZE        - default program address width
//             c_CSIZE        - default control word width
//             fifo_has_room  - true when a 2-entry buffer can take a word
//  Revision : 1.0 - initial release
// ============================================================================
package nisc_pkg;

  localparam int c_PSIZE = 6;
  localparam int c_CSIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // A 2-entry buffer has room for another word while it holds fewer than 2.
  function automatic logic fifo_has_room(input logic [1:0] n);
    return (n < 2'd2);
  endfunction

endpackage : nisc_pkg
`default_nettype wire

// File: rtl/cw_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cw_fifo
//  Purpose  : 2-entry control-word buffer between program memory and the
//             datapath. Entry 0 is always the head, so a pop is a shift.
//  Ports    : clk        in   clock, rising edge
//             Reset      in   asynchronous active-high reset
//             clear      in   empty the buffer at the next edge (wins over pop)
//             push       in   write din behind the current contents
//             din        in   word to push
//             pop        in   remove the head (ignored when empty or clearing)
//             count      out  entries held (0..2)
//             count_next out  occupancy after this cycle's push/pop/clear
//             head       out  head entry, 0 when empty
//  Revision : 1.0 - initial release
// ============================================================================
module cw_fifo #(
  parameter int Csize = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             push,
  input  logic [Csize-1:0] din,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [1:0]       count_next,
  output logic [Csize-1:0] head
);

  logic [Csize-1:0] r_e0;
  logic [Csize-1:0] r_e1;
  logic [1:0]       r_count;

  logic             w_pop;
  logic [1:0]       w_base;
  logic [Csize-1:0] w_e0_nx;
  logic [Csize-1:0] w_e1_nx;

  always_comb begin
    w_pop   = pop && (r_count != 2'd0) && !clear;
    // Slot the pushed word lands in: first free slot after any pop shift.
    w_base  = r_count - {1'b0, w_pop};
    w_e0_nx = w_pop ? r_e1 : r_e0;
    w_e1_nx = r_e1;
    if (push && !clear) begin
      if (w_base == 2'd0) begin
        w_e0_nx = din;
      end else begin
        w_e1_nx = din;
      end
    end
    if (clear) begin
      count_next = 2'd0;
    end else begin
      count_next = w_base + {1'b0, push};
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_count <= 2'd0;
    end else begin
      r_e0    <= w_e0_nx;
      r_e1    <= w_e1_nx;
      r_count <= count_next;
    end
  end

  assign count = r_count;
  // Stale data may sit in r_e0 after a clear; never expose it.
  assign head  = (r_count != 2'd0) ? r_e0 : '0;

endmodule : cw_fifo
`default_nettype wire

// File: rtl/cw_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : cw_fetch
//  Purpose  : Control-word fetch unit. Reads the word at pc_addr from program
//             memory (any number of wait states), queues it in a 2-entry
//             buffer toward the datapath, and drops pc_hold for exactly one
//             cycle per accepted word so the PC advances once per fetch.
//  Ports    : clk        in   clock, rising edge
//             Reset      in   asynchronous active-high reset
//             pc_addr    in   current PC
//             pc_hold    out  0 = PC increments at the next edge
//             flush      in   discard buffered and in-flight words
//             mem_req    out  program memory read request
//             mem_addr   out  read address (0 when not requesting)
//             mem_ack    in   read complete, mem_rdata valid this cycle
//             mem_rdata  in   control word from memory
//             cw_valid   out  buffer head valid
//             cw         out  buffer head word (0 when empty)
//             cw_ready   in   datapath takes the head when cw_valid & cw_ready
//  Revision : 1.0 - initial release
// ============================================================================
module cw_fetch
  import nisc_pkg::*;
#(
  parameter int Psize = c_PSIZE,
  parameter int Csize = c_CSIZE
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [Psize-1:0] pc_addr,
  output logic             pc_hold,
  input  logic             flush,
  output logic             mem_req,
  output logic [Psize-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [Csize-1:0] mem_rdata,
  output logic             cw_valid,
  output logic [Csize-1:0] cw,
  input  logic             cw_ready
);

  fetch_state_t r_state;
  fetch_state_t w_state_nx;

  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count;
  logic [1:0]   w_count_nx;

  assign w_pop = cw_valid && cw_ready;

  cw_fifo #(
    .Csize (Csize)
  ) u_fifo (
    .clk        (clk),
    .Reset      (Reset),
    .clear      (flush),
    .push       (w_push),
    .din        (mem_rdata),
    .pop        (w_pop),
    .count      (w_count),
    .count_next (w_count_nx),
    .head       (cw)
  );

  assign cw_valid = (w_count != 2'd0);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // A request is only issued while the buffer will have room, so a push
  // never needs an overflow check. PC stays put (hold=1) for the whole read,
  // which keeps mem_addr stable until the ack.
  always_comb begin
    w_state_nx = r_state;
    mem_req    = 1'b0;
    pc_hold    = 1'b1;
    w_push     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!flush && fifo_has_room(w_count_nx)) begin
          w_state_nx = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          if (flush) begin
            w_state_nx = IDLE;
          end else begin
            w_push     = 1'b1;
            pc_hold    = 1'b0;
            w_state_nx = fifo_has_room(w_count_nx) ? REQ : IDLE;
          end
        end else if (flush) begin
          w_state_nx = DROP;
        end
      end
      DROP: begin
        // Finish the read the memory already started, then throw it away.
        mem_req = 1'b1;
        if (mem_ack) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign mem_addr = mem_req ? pc_addr : '0;

endmodule : cw_fetch
`default_nettype wire

// File: tb/tb_cw_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cw_fetch
//  Purpose  : Self-checking bench for cw_fetch. A stand-in PC register follows
//             pc_hold, a memory model answers reads after a chosen number of
//             wait states, and a transaction-level model (expected PC plus a
//             queue of expected words) predicts every cycle's outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cw_fetch;

  localparam int P = 3;
  localparam int C = 16;
  localparam int NADDR = 1 << P;

  logic          clk = 1'b0;
  logic          Reset = 1'b0;
  logic [P-1:0]  pc_addr;
  logic          pc_hold;
  logic          flush = 1'b0;
  logic          mem_req;
  logic [P-1:0]  mem_addr;
  logic          mem_ack = 1'b0;
  logic [C-1:0]  mem_rdata = '0;
  logic          cw_valid;
  logic [C-1:0]  cw;
  logic          cw_ready = 1'b0;

  cw_fetch #(
    .Psize (P),
    .Csize (C)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .pc_addr   (pc_addr),
    .pc_hold   (pc_hold),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .cw_valid  (cw_valid),
    .cw        (cw),
    .cw_ready  (cw_ready)
  );

  always #5 clk = ~clk;

  // Stand-in for the pc block.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) pc_addr <= '0;
    else if (!pc_hold) pc_addr <= pc_addr + 1'b1;
  end

  logic [C-1:0] mem [0:NADDR-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [C-1:0] q[$];
  int           model_pc;
  bit           busy;
  int           wait_left;
  bit           doomed;
  bit           pend_prev;
  logic [P-1:0] addr_prev;
  int           delivered;

  // Stimulus knobs
  int g_ready_pct;
  int g_wait;        // <0: random 0..3 wait states per read
  int g_flush_mode;  // 0 none, 1 random, 2 once on a pending read
  bit g_flush_fired;

  task automatic model_clear();
    q.delete();
    model_pc  = 0;
    busy      = 1'b0;
    wait_left = 0;
    doomed    = 1'b0;
    pend_prev = 1'b0;
    addr_prev = '0;
  endtask

  task automatic step();
    bit accept;
    bit consume;
    @(negedge clk);
    if (mem_req && !busy) begin
      busy      = 1'b1;
      wait_left = (g_wait < 0) ? int'($urandom_range(0, 3)) : g_wait;
    end
    mem_ack   = busy && (wait_left == 0);
    mem_rdata = mem_ack ? mem[mem_addr] : C'($urandom);
    cw_ready  = ($urandom_range(0, 99) < g_ready_pct);
    case (g_flush_mode)
      1:       flush = ($urandom_range(0, 15) == 0);
      2:       flush = mem_req && !mem_ack;
      default: flush = 1'b0;
    endcase
    if (g_flush_mode == 2 && flush) begin
      g_flush_mode  = 0;
      g_flush_fired = 1'b1;
    end
    #1;
    if (pend_prev) begin
      chk("hs_req_held", 32'(mem_req), 32'd1);
      chk("hs_addr_held", 32'(mem_addr), 32'(addr_prev));
    end
    chk("mem_addr", 32'(mem_addr), mem_req ? 32'(model_pc) : 32'd0);
    chk("pc_track", 32'(pc_addr), 32'(model_pc));
    accept = mem_req && mem_ack && !flush && !doomed;
    chk("pc_hold", 32'(pc_hold), 32'(!accept));
    chk("cw_valid", 32'(cw_valid), 32'(q.size() != 0));
    chk("cw", 32'(cw), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    if (q.size() == 2) chk("full_no_req", 32'(mem_req), 32'd0);

    consume = (q.size() != 0) && cw_ready && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (consume) begin
        void'(q.pop_front());
        delivered++;
      end
      if (accept) q.push_back(mem[model_pc]);
    end
    if (accept) model_pc = (model_pc + 1) % NADDR;
    if (busy && !mem_ack && flush) doomed = 1'b1;
    if (mem_ack) begin
      busy   = 1'b0;
      doomed = 1'b0;
    end else if (busy) begin
      wait_left--;
    end
    pend_prev = mem_req && !mem_ack;
    addr_prev = mem_addr;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    mem_ack  = 1'b0;
    flush    = 1'b0;
    cw_ready = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc_hold", 32'(pc_hold), 32'd1);
    chk("rst_cw_valid", 32'(cw_valid), 32'd0);
    chk("rst_cw", 32'(cw), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_during", 32'(pc_hold), 32'd1);
    Reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int budget;
    model_clear();
    delivered     = 0;
    g_flush_mode  = 0;
    g_flush_fired = 1'b0;

    // 1/5: zero-wait stream with wrap, words 0x100+addr
    for (int i = 0; i < NADDR; i++) mem[i] = 16'h0100 + 16'(i);
    g_ready_pct = 100;
    g_wait      = 0;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      step();
      if (k == 0) chk("p1_first_idle", 32'(mem_req), 32'd0);
      if (k >= 1) begin
        chk("p1_req", 32'(mem_req), 32'd1);
        chk("p1_hold_low", 32'(pc_hold), 32'd0);
      end
      if (k < 2) begin
        chk("p1_valid_early", 32'(cw_valid), 32'd0);
      end else begin
        chk("p1_valid", 32'(cw_valid), 32'd1);
        chk("p1_word", 32'(cw), 32'h100 + 32'((k - 2) % NADDR));
      end
    end

    // 2: three wait states per read
    for (int i = 0; i < NADDR; i++) mem[i] = C'($urandom);
    g_wait    = 3;
    delivered = 0;
    budget    = 0;
    while (delivered < 10 && budget < 200) begin
      step();
      budget++;
    end
    chk("p2_progress", 32'(delivered >= 10), 32'd1);

    // 3: back-pressure fills the buffer and freezes the PC
    g_wait      = 0;
    g_ready_pct = 0;
    do_reset();
    repeat (6) step();
    chk("p3_req_off", 32'(mem_req), 32'd0);
    chk("p3_hold", 32'(pc_hold), 32'd1);
    chk("p3_pc", 32'(pc_addr), 32'd2);
    chk("p3_valid", 32'(cw_valid), 32'd1);
    chk("p3_head", 32'(cw), 32'(mem[0]));
    g_ready_pct = 100;
    repeat (12) step();

    // 4: flush while a 2-wait read is pending
    g_wait        = 2;
    g_flush_fired = 1'b0;
    g_flush_mode  = 2;
    budget        = 0;
    while (!g_flush_fired && budget < 50) begin
      step();
      budget++;
    end
    chk("p4_flush_seen", 32'(g_flush_fired), 32'd1);
    step();
    chk("p4_drop_req", 32'(mem_req), 32'd1);
    chk("p4_drop_valid", 32'(cw_valid), 32'd0);
    g_flush_mode = 0;
    repeat (20) step();

    // 6: reset in the middle of a read with one word buffered
    g_ready_pct = 0;
    g_wait      = 3;
    budget      = 0;
    while (!(q.size() == 1 && mem_req && !mem_ack) && budget < 60) begin
      step();
      budget++;
    end
    chk("p6_setup", 32'(q.size() == 1 && mem_req && !mem_ack), 32'd1);
    do_reset();

    // Randomised soak
    g_ready_pct  = 70;
    g_wait       = -1;
    g_flush_mode = 1;
    delivered    = 0;
    repeat (1500) step();
    chk("soak_progress", 32'(delivered > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_cw_fetch
`default_nettype wire
